// File: rtl/sgpu_i_chal.sv
// sgpu_i_chal: SGPU input channel. Packs 32-bit pixel pairs into 64-bit words,
// buffers them in a small FIFO and writes one frame to memory as an ICB initiator.
`ifndef MYRISCV_ADDRBUS
`define MYRISCV_ADDRBUS 31:0
`endif

module sgpu_i_chal #(
    parameter int SCR_W      = 800,
    parameter int SCR_H      = 600,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_OUTSTD = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    openChal,
    input  logic [`MYRISCV_ADDRBUS] base_addr,
    input  logic                    w_req,
    input  logic [31:0]             data_i,
    output logic                    full,
    output logic                    done,
    output logic [1:0]              err,
    output logic                    icb_cmd_vld,
    input  logic                    icb_cmd_rdy,
    output logic                    icb_cmd_read,
    output logic [`MYRISCV_ADDRBUS] icb_cmd_addr,
    output logic [63:0]             icb_cmd_wdata,
    output logic [7:0]              icb_cmd_wmask,
    input  logic                    icb_rsp_vld,
    output logic                    icb_rsp_rdy,
    input  logic [63:0]             icb_rsp_rdata,
    input  logic                    icb_rsp_err
);
    localparam int TOTAL  = SCR_W * SCR_H / 2;
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W  = $clog2(MAX_OUTSTD + 1);
    localparam logic [CNT_W-1:0]  TOTAL_C = CNT_W'(TOTAL);
    localparam logic [FCNT_W-1:0] DEPTH_C = FCNT_W'(FIFO_DEPTH);
    localparam logic [OUT_W-1:0]  MAXO_C  = OUT_W'(MAX_OUTSTD);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]              r_state;
    logic [CNT_W-1:0]        r_cmd_cnt;
    logic [`MYRISCV_ADDRBUS] r_addr;
    logic [OUT_W-1:0]        r_outstd;
    logic [1:0]              r_err;
    logic                    r_full;
    logic                    r_half;
    logic [31:0]             r_first;
    logic [63:0]             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wp;
    logic [PTR_W-1:0]        r_rp;
    logic [FCNT_W-1:0]       r_fcnt;

    logic              w_run;
    logic              w_acc;
    logic              w_push;
    logic              w_cmd_hs;
    logic              w_rsp_hs;
    logic [FCNT_W-1:0] w_fcnt_nxt;
    logic [OUT_W-1:0]  w_outstd_nxt;
    logic              w_unused_rdata;

    assign w_run          = (r_state == S_RUN);
    assign w_acc          = w_run && w_req && !r_full;
    assign w_push         = w_acc && r_half;
    assign w_cmd_hs       = icb_cmd_vld && icb_cmd_rdy;
    assign w_rsp_hs       = icb_rsp_vld;
    assign w_unused_rdata = ^icb_rsp_rdata;

    assign icb_cmd_vld   = w_run && (r_fcnt != '0) && (r_outstd < MAXO_C);
    assign icb_cmd_addr  = r_addr;
    assign icb_cmd_wdata = (r_fcnt != '0) ? r_mem[r_rp] : 64'd0;
    assign icb_cmd_read  = 1'b0;
    assign icb_cmd_wmask = 8'hff;
    assign icb_rsp_rdy   = 1'b1;
    assign full          = r_full;
    assign done          = (r_state == S_DONE);
    assign err           = r_err;

    always_comb begin
        w_fcnt_nxt = r_fcnt;
        if (w_push && !w_cmd_hs)
            w_fcnt_nxt = r_fcnt + 1'b1;
        else if (!w_push && w_cmd_hs)
            w_fcnt_nxt = r_fcnt - 1'b1;

        // A stray response with nothing outstanding must not wrap the counter.
        w_outstd_nxt = r_outstd;
        if (w_cmd_hs && !w_rsp_hs)
            w_outstd_nxt = r_outstd + 1'b1;
        else if (!w_cmd_hs && w_rsp_hs && (r_outstd != '0))
            w_outstd_nxt = r_outstd - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_acc && !r_half)
            r_first <= data_i;
        if (w_push)
            r_mem[r_wp] <= {data_i, r_first};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cmd_cnt <= '0;
            r_addr    <= '0;
            r_outstd  <= '0;
            r_err     <= 2'b00;
            r_full    <= 1'b0;
            r_half    <= 1'b0;
            r_wp      <= '0;
            r_rp      <= '0;
            r_fcnt    <= '0;
        end else begin
            // outstd keeps counting through an abort so late responses drain it
            r_outstd <= w_outstd_nxt;
            r_err    <= r_err | {w_req && !w_acc, w_rsp_hs && icb_rsp_err};
            if (w_cmd_hs) begin
                r_cmd_cnt <= r_cmd_cnt + 1'b1;
                r_addr    <= r_addr + 8;
            end

            if (!openChal) begin
                r_state   <= S_IDLE;
                r_cmd_cnt <= '0;
                r_half    <= 1'b0;
                r_wp      <= '0;
                r_rp      <= '0;
                r_fcnt    <= '0;
                r_full    <= 1'b0;
            end else begin
                if (w_push)
                    r_wp <= r_wp + 1'b1;
                if (w_cmd_hs)
                    r_rp <= r_rp + 1'b1;
                r_fcnt <= w_fcnt_nxt;
                r_full <= (w_fcnt_nxt == DEPTH_C);
                if (w_acc)
                    r_half <= !r_half;

                case (r_state)
                    S_IDLE: begin
                        if (r_outstd == '0) begin
                            r_state   <= S_RUN;
                            r_cmd_cnt <= '0;
                            r_addr    <= base_addr;
                            r_err     <= 2'b00;
                        end
                    end
                    S_RUN: begin
                        // leave RUN on the handshake that completes the frame
                        if (w_cmd_hs && (r_cmd_cnt == TOTAL_C - 1'b1))
                            r_state <= S_DRAIN;
                    end
                    S_DRAIN: begin
                        if (w_outstd_nxt == '0)
                            r_state <= S_DONE;
                    end
                    default: r_state <= S_DONE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sgpu_i_chal.sv
// Bench for sgpu_i_chal: directed pixel streams, a queue-based frame model
// compared every cycle, and hand-computed expectations per scenario.
`ifndef MYRISCV_ADDRBUS
`define MYRISCV_ADDRBUS 31:0
`endif

module tb_sgpu_i_chal;
    localparam int SW    = 16;
    localparam int SH    = 2;
    localparam int TOTAL = SW * SH / 2;
    localparam int DEPTH = 16;
    localparam int MAXO  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        openChal = 1'b0;
    logic [31:0] base_addr = '0;
    logic        w_req = 1'b0;
    logic [31:0] data_i = '0;
    logic        full;
    logic        done;
    logic [1:0]  err;
    logic        icb_cmd_vld;
    logic        icb_cmd_rdy = 1'b0;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_addr;
    logic [63:0] icb_cmd_wdata;
    logic [7:0]  icb_cmd_wmask;
    logic        icb_rsp_vld = 1'b0;
    logic        icb_rsp_rdy;
    logic [63:0] icb_rsp_rdata = '0;
    logic        icb_rsp_err = 1'b0;

    sgpu_i_chal #(.SCR_W(SW), .SCR_H(SH), .FIFO_DEPTH(DEPTH), .MAX_OUTSTD(MAXO)) dut (
        .clk(clk), .rst(rst), .openChal(openChal), .base_addr(base_addr),
        .w_req(w_req), .data_i(data_i), .full(full), .done(done), .err(err),
        .icb_cmd_vld(icb_cmd_vld), .icb_cmd_rdy(icb_cmd_rdy), .icb_cmd_read(icb_cmd_read),
        .icb_cmd_addr(icb_cmd_addr), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_vld(icb_rsp_vld), .icb_rsp_rdy(icb_rsp_rdy), .icb_rsp_rdata(icb_rsp_rdata),
        .icb_rsp_err(icb_rsp_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: phase 0 idle, 1 run, 2 drain, 3 done
    int          m_ph = 0;
    logic [63:0] m_q[$];
    logic        m_half = 1'b0;
    logic [31:0] m_first = '0;
    int          m_k = 0;
    logic [31:0] m_base = '0;
    int          m_out = 0;
    logic [1:0]  m_err = 2'b00;
    bit          m_valid = 1'b0;

    logic [31:0] hs_addr[$];
    logic [63:0] hs_data[$];
    int          rsp_sent = 0;
    bit          auto_rsp = 1'b0;

    always @(negedge clk) begin
        logic e_vld, e_full, hs, rsp, acc, drop;
        int   old_out;
        e_vld  = (m_ph == 1) && (m_q.size() > 0) && (m_out < MAXO);
        e_full = (m_q.size() == DEPTH);
        if (m_valid) begin
            chk("cmd_vld", 64'(icb_cmd_vld), 64'(e_vld));
            chk("full", 64'(full), 64'(e_full));
            chk("done", 64'(done), 64'(m_ph == 3));
            chk("err", 64'(err), 64'(m_err));
            chk("const_outs", {icb_cmd_read, icb_rsp_rdy, icb_cmd_wmask}, {1'b0, 1'b1, 8'hff});
            if (e_vld) begin
                chk("cmd_addr", 64'(icb_cmd_addr), 64'(m_base + 32'(8 * m_k)));
                chk("cmd_wdata", icb_cmd_wdata, m_q[0]);
            end
        end
        if (icb_cmd_vld && icb_cmd_rdy) begin
            hs_addr.push_back(icb_cmd_addr);
            hs_data.push_back(icb_cmd_wdata);
        end
        if (rst) begin
            m_ph = 0; m_q.delete(); m_half = 1'b0; m_k = 0;
            m_base = '0; m_out = 0; m_err = 2'b00; m_valid = 1'b1;
        end else begin
            hs   = e_vld && icb_cmd_rdy;
            rsp  = icb_rsp_vld;
            acc  = (m_ph == 1) && w_req && !e_full;
            drop = w_req && !acc;
            m_err = m_err | {drop, rsp && icb_rsp_err};
            if (hs) begin
                void'(m_q.pop_front());
                m_k++;
            end
            if (acc) begin
                if (m_half) m_q.push_back({data_i, m_first});
                else        m_first = data_i;
                m_half = !m_half;
            end
            old_out = m_out;
            if (hs && !rsp) m_out++;
            else if (!hs && rsp && m_out > 0) m_out--;
            if (!openChal) begin
                m_ph = 0; m_q.delete(); m_half = 1'b0; m_k = 0;
            end else begin
                case (m_ph)
                    0: if (old_out == 0) begin m_ph = 1; m_k = 0; m_base = base_addr; m_err = 2'b00; end
                    1: if (hs && m_k == TOTAL) m_ph = 2;
                    2: if (m_out == 0) m_ph = 3;
                    default: ;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_rsp) begin
            if (hs_addr.size() > rsp_sent) begin
                icb_rsp_vld = 1'b1;
                rsp_sent++;
            end else begin
                icb_rsp_vld = 1'b0;
            end
        end
    endtask

    task automatic respond(input logic e);
        icb_rsp_vld = 1'b1;
        icb_rsp_err = e;
        rsp_sent++;
        tick();
        icb_rsp_vld = 1'b0;
        icb_rsp_err = 1'b0;
    endtask

    task automatic push_pix(input logic [31:0] d);
        w_req  = 1'b1;
        data_i = d;
        tick();
        w_req  = 1'b0;
    endtask

    task automatic wait_hs(input int target, input int budget, input string nm);
        int c = 0;
        while (hs_addr.size() < target && c < budget) begin
            tick();
            c++;
        end
        chk(nm, 64'(hs_addr.size()), 64'(target));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int c;
        // reset with activity on the inputs
        rst = 1'b1;
        openChal = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_req = (i % 2 == 1);
            data_i = 32'h1234_0000 + 32'(i);
            tick();
        end
        w_req = 1'b0;
        openChal = 1'b0;
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_vld", 64'(icb_cmd_vld), 64'(0));
        chk("rst_addr", 64'(icb_cmd_addr), 64'(0));
        chk("rst_wdata", icb_cmd_wdata, 64'd0);
        chk("rst_consts", {icb_cmd_read, icb_rsp_rdy, icb_cmd_wmask}, {1'b0, 1'b1, 8'hff});
        rst = 1'b0;
        tick();

        // packing
        b0 = hs_addr.size();
        base_addr = 32'h8000_0000;
        icb_cmd_rdy = 1'b1;
        openChal = 1'b1;
        tick();
        push_pix(32'h1111_1111);
        push_pix(32'h2222_2222);
        push_pix(32'h3333_3333);
        push_pix(32'h4444_4444);
        wait_hs(b0 + 2, 20, "pack_count");
        chk("pack_addr0", 64'(hs_addr[b0]), 64'h8000_0000);
        chk("pack_data0", hs_data[b0], 64'h2222_2222_1111_1111);
        chk("pack_addr1", 64'(hs_addr[b0+1]), 64'h8000_0008);
        chk("pack_data1", hs_data[b0+1], 64'h4444_4444_3333_3333);
        respond(1'b0);
        respond(1'b0);
        openChal = 1'b0;
        tick();

        // backpressure, full and dropped pixels, then a whole frame drains
        b0 = hs_addr.size();
        base_addr = 32'h0000_1000;
        icb_cmd_rdy = 1'b0;
        openChal = 1'b1;
        tick();
        for (int i = 0; i < 34; i++) begin
            w_req = 1'b1;
            data_i = 32'hA000_0000 + 32'(i);
            tick();
        end
        w_req = 1'b0;
        chk("bp_full", 64'(full), 64'(1));
        chk("bp_err", 64'(err), 64'(2'b10));
        chk("bp_no_write", 64'(hs_addr.size()), 64'(b0));
        icb_cmd_rdy = 1'b1;
        auto_rsp = 1'b1;
        wait_hs(b0 + 16, 80, "bp_count");
        for (int j = 0; j < 16; j++) begin
            chk("bp_addr", 64'(hs_addr[b0+j]), 64'(32'h0000_1000 + 32'(8 * j)));
            chk("bp_data", hs_data[b0+j],
                {32'hA000_0000 + 32'(2 * j + 1), 32'hA000_0000 + 32'(2 * j)});
        end
        c = 0;
        while (!done && c < 40) begin tick(); c++; end
        chk("bp_done", 64'(done), 64'(1));
        auto_rsp = 1'b0;
        icb_rsp_vld = 1'b0;
        openChal = 1'b0;
        tick();
        chk("bp_done_clear", 64'(done), 64'(0));

        // stray response while idle must not disturb the outstanding count
        icb_rsp_vld = 1'b1;
        tick();
        icb_rsp_vld = 1'b0;

        // outstanding limit
        b0 = hs_addr.size();
        base_addr = 32'h0000_2000;
        icb_cmd_rdy = 1'b0;
        openChal = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            w_req = 1'b1;
            data_i = 32'hB000_0000 + 32'(i);
            tick();
        end
        w_req = 1'b0;
        icb_cmd_rdy = 1'b1;
        repeat (10) tick();
        chk("lim_count4", 64'(hs_addr.size()), 64'(b0 + 4));
        chk("lim_vld_low", 64'(icb_cmd_vld), 64'(0));
        respond(1'b0);
        repeat (5) tick();
        chk("lim_count5", 64'(hs_addr.size()), 64'(b0 + 5));
        chk("lim_vld_low2", 64'(icb_cmd_vld), 64'(0));

        // abort with four responses pending, then reopen at once
        openChal = 1'b0;
        tick();
        openChal = 1'b1;
        repeat (3) tick();
        push_pix(32'hDEAD_0000);
        respond(1'b0);
        tick();
        respond(1'b0);
        respond(1'b0);
        respond(1'b1);
        chk("abort_err", 64'(err), 64'(2'b11));
        chk("abort_vld", 64'(icb_cmd_vld), 64'(0));
        tick();
        chk("restart_err_clear", 64'(err), 64'(0));
        b0 = hs_addr.size();
        push_pix(32'h0000_00C1);
        push_pix(32'h0000_00C2);
        wait_hs(b0 + 1, 10, "restart_count");
        chk("restart_addr", 64'(hs_addr[b0]), 64'h0000_2000);
        chk("restart_data", hs_data[b0], 64'h0000_00C2_0000_00C1);
        respond(1'b0);
        openChal = 1'b0;
        tick();

        // full frame with hand-paced responses and done timing
        b0 = hs_addr.size();
        base_addr = 32'h0000_3000;
        icb_cmd_rdy = 1'b1;
        openChal = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            w_req = 1'b1;
            data_i = 32'h5000_0000 + 32'(i);
            tick();
        end
        w_req = 1'b0;
        for (int r = 0; r < TOTAL; r++) begin
            c = 0;
            while (hs_addr.size() <= rsp_sent && c < 20) begin tick(); c++; end
            if (r == TOTAL - 1)
                chk("frame_done_before", 64'(done), 64'(0));
            respond(1'b0);
        end
        chk("frame_done_after", 64'(done), 64'(1));
        chk("frame_count", 64'(hs_addr.size()), 64'(b0 + TOTAL));
        for (int j = 0; j < TOTAL; j++) begin
            chk("frame_addr", 64'(hs_addr[b0+j]), 64'(32'h0000_3000 + 32'(8 * j)));
            chk("frame_data", hs_data[b0+j],
                {32'h5000_0000 + 32'(2 * j + 1), 32'h5000_0000 + 32'(2 * j)});
        end
        openChal = 1'b0;
        tick();
        chk("frame_done_clear", 64'(done), 64'(0));
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
